dk_sound_mixer: RTL
===================

# dk_sound_mixer

Downstream sink for the discrete sound-effect circuits (walk, jump, stomp, etc.), each producing a signed 16-bit sample per `audio_clk_en`. It snapshots all channel samples on each sample strobe and time-multiplexes one multiplier to apply per-channel gain. It then accumulates, saturates and registers a single signed 16-bit sample for the audio output path. An optional DC-blocking stage removes the offsets that the inverter and filter stages leave on their outputs.

## Interface
Parameters:
- `NUM_CHANNELS`, 4: number of mixed inputs, 1..8.
- `DC_SHIFT`, 10: DC-blocker pole, where leak = y>>>DC_SHIFT; used only with the macro.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `I_RSTn`  in  1  reset, asynchronous, active-low.
- `audio_clk_en`  in  1  sample strobe, one cycle wide.
- `in[NUM_CHANNELS]`  in  16 each  signed channel samples.
- `gain[NUM_CHANNELS]`  in  8 each  unsigned Q1.7 gain; 128 = unity, 255 ≈ 1.99.
- `out`  out  16  signed mixed sample, registered.
- `out_valid`  out  1  one-cycle pulse when `out` updates.
- `overrun`  out  1  sticky; a strobe arrived while busy.

## Operation
- States: IDLE, ACCUM, SAT, plus DC when the macro is defined.
- IDLE: an edge with `audio_clk_en`=1 snapshots all `in` and `gain` into registers, clears the accumulator, sets channel index 0 and moves to ACCUM.
- ACCUM: each cycle acc += snap_in[i] * $signed({1'b0, snap_gain[i]}).
  - Product is 25-bit signed; acc is 25+$clog2(NUM_CHANNELS) bits, so it cannot overflow.
  - Moves to SAT after index NUM_CHANNELS-1.
- SAT: r = acc >>> 7, arithmetic shift (floor). r is clamped to [-32768, 32767].
  - Without DC: r is written to `out`, `out_valid` is pulsed and the state returns to IDLE.
  - With DC: r is passed to the DC state.
- DC: y = r − x_prev + y_prev − (y_prev >>> DC_SHIFT), computed at 18-bit width and then saturated to 16 bits.
  - x_prev ← r, y_prev ← y.
  - y is written to `out`, `out_valid` is pulsed and the state returns to IDLE.
- `audio_clk_en` in any state other than IDLE is ignored for mixing and sets `overrun`=1. `overrun` clears only on reset.
- Input changes after the snapshot edge do not affect the sample in flight.
- `out` holds its value between updates.

## Timing
- Reset values: `out`=0, `out_valid`=0, `overrun`=0. Reset also sets state IDLE and clears acc, snapshots, x_prev and y_prev.
- Reset asserted mid-operation: all of the above return to reset values immediately, with no partial output.
- Latency without DC: strobe at edge E0 → `out`/`out_valid` updated at edge E(NUM_CHANNELS+1). With default N=4 that is 5 cycles.
- Latency with DC: E(NUM_CHANNELS+2).
- `out_valid` is high for exactly one cycle per accepted strobe.
- Minimum strobe spacing for no overrun: NUM_CHANNELS+2 cycles (+1 with DC). A strobe landing on the same edge the block returns to IDLE is accepted.

## Configuration
- `DK_MIXER_DC_BLOCK_EN` defined: the DC state and the DC-blocker stage are present and latency is +1 cycle.
- Undefined: SAT writes `out` directly, and no DC registers are instantiated.

## Structure
- Package `dk_sound_pkg` holds:
  - `sample_t` (logic signed [15:0]) and `gain_t` (logic [7:0]);
  - `GAIN_UNITY`=128 and `GAIN_FRAC_BITS`=7;
  - the mixer state enum;
  - function `sat16` (wide signed to 16-bit clamp).
- One sub-module, `dc_blocker`: one-pole high-pass with a valid in/out handshake, compiled in under the macro.

## Test plan
- Reset: hold `I_RSTn`=0 with random inputs → `out`=0, `out_valid`=0, `overrun`=0. Release, with no strobe → outputs remain 0.
- Single channel (no DC): in[0]=1000, gain[0]=128, other channels 0 → `out`=1000 with a 1-cycle `out_valid`, 5 cycles after the strobe. With gain[0]=64 → `out`=500.
- Saturation: all in=30000, gains=255 → `out`=32767. All in=-30000 → `out`=-32768.
- Snapshot and overrun: strobe, change in[0] to -5000 at E1, strobe again at E2.
  - The result uses the original in[0].
  - `overrun`=1 and only one `out_valid` pulse occurs.
- Reset mid-ACCUM: assert `I_RSTn`=0 at E2 → `out`=0 and no `out_valid`. The next strobe after release mixes normally.
- DC (macro defined, DC_SHIFT=10): constant in[0]=8192 at unity gain → first output 8192, then monotonically decaying. After 1024 strobes the output is at or below 8192·e⁻¹ ± 2%.

Source files
------------

// File: rtl/dk_sound_pkg.sv
// Shared types, constants and helpers for the discrete-sound mixer.
// Sample and gain types, the Q1.7 gain format, the mixer state encoding
// and the 16-bit saturating clamp live here.
package dk_sound_pkg;

    typedef logic signed [15:0] sample_t;
    typedef logic [7:0]         gain_t;

    localparam int GAIN_UNITY     = 128;
    localparam int GAIN_FRAC_BITS = 7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_SAT   = 2'd2,
        ST_DC    = 2'd3
    } mix_state_t;

    // Clamp a wide signed value into the 16-bit sample range.
    function automatic sample_t sat16(input logic signed [31:0] v);
        if (v > 32'sd32767) begin
            return 16'sh7FFF;
        end else if (v < -32'sd32768) begin
            return 16'sh8000;
        end else begin
            return v[15:0];
        end
    endfunction

endpackage

// File: rtl/dk_sound_mixer_if.sv
// Channel-side bus of the sound mixer: sample strobe, per-channel samples
// and gains, plus the mixed output with its valid pulse and overrun flag.
// master = sound sources / audio path, slave = mixer.
interface dk_sound_mixer_if #(
    parameter int NUM_CHANNELS = 4
);
    import dk_sound_pkg::*;

    logic    audio_clk_en;
    sample_t in   [NUM_CHANNELS];
    gain_t   gain [NUM_CHANNELS];
    sample_t out;
    logic    out_valid;
    logic    overrun;

    modport master (
        output audio_clk_en, in, gain,
        input  out, out_valid, overrun
    );

    modport slave (
        input  audio_clk_en, in, gain,
        output out, out_valid, overrun
    );

endinterface

// File: rtl/dk_sound_mixer_dc_blocker.sv
// One-pole DC-blocking high-pass: y = x - x_prev + y_prev - (y_prev >>> DC_SHIFT).
// Evaluated at 18 bits so the intermediate sum cannot wrap, then clamped
// to 16 bits. The registered output doubles as y_prev.
// Only present when DK_MIXER_DC_BLOCK_EN is defined.
`ifdef DK_MIXER_DC_BLOCK_EN
module dc_blocker
    import dk_sound_pkg::*;
#(
    parameter int DC_SHIFT = 10
) (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    in_valid,
    input  sample_t x,
    output logic    out_valid,
    output sample_t y
);

    sample_t            x_prev;
    logic signed [17:0] sum;

    // Filter difference equation on the incoming sample.
    always_comb begin
        sum = 18'(x) - 18'(x_prev) + 18'(y) - 18'(y >>> DC_SHIFT);
    end

    // Update filter history and the output on each accepted sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_prev    <= '0;
            y         <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                x_prev <= x;
                y      <= sat16(32'(sum));
            end
        end
    end

endmodule
`endif

// File: rtl/dk_sound_mixer.sv
// Discrete sound-effect mixer. Snapshots all channels on audio_clk_en,
// walks them through one shared multiplier applying Q1.7 gain, then
// floors, saturates and registers a 16-bit output sample.
// Optional build macro: DK_MIXER_DC_BLOCK_EN adds a DC-blocking stage
// (one extra cycle of latency).
module dk_sound_mixer
    import dk_sound_pkg::*;
#(
    parameter int NUM_CHANNELS = 4,
    parameter int DC_SHIFT     = 10
) (
    input logic             clk,
    input logic             I_RSTn,
    dk_sound_mixer_if.slave bus
);

    localparam int IDX_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam int ACC_W = 25 + $clog2(NUM_CHANNELS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHANNELS - 1);

    if (NUM_CHANNELS < 1 || NUM_CHANNELS > 8) begin : g_bad_channels
        $error("NUM_CHANNELS must be 1..8");
    end
    if (DC_SHIFT < 1 || DC_SHIFT > 15) begin : g_bad_shift
        $error("DC_SHIFT must be 1..15");
    end

    mix_state_t              state;
    sample_t                 snap_in   [NUM_CHANNELS];
    gain_t                   snap_gain [NUM_CHANNELS];
    logic [IDX_W-1:0]        idx;
    logic signed [ACC_W-1:0] acc;
    logic signed [24:0]      prod;
    sample_t                 mix;

    // Shared multiplier and the floor/saturate of the accumulated mix.
    always_comb begin
        prod = 25'(snap_in[idx]) * 25'($signed({1'b0, snap_gain[idx]}));
        mix  = sat16(32'(acc >>> GAIN_FRAC_BITS));
    end

`ifdef DK_MIXER_DC_BLOCK_EN
    logic    dc_valid;
    sample_t dc_y;

    dc_blocker #(
        .DC_SHIFT (DC_SHIFT)
    ) u_dc_blocker (
        .clk       (clk),
        .rst_n     (I_RSTn),
        .in_valid  (state == ST_SAT),
        .x         (mix),
        .out_valid (dc_valid),
        .y         (dc_y)
    );
`endif

    // Mixer sequencer: snapshot, accumulate per channel, saturate, publish.
    always_ff @(posedge clk or negedge I_RSTn) begin
        if (!I_RSTn) begin
            state         <= ST_IDLE;
            idx           <= '0;
            acc           <= '0;
            bus.out       <= '0;
            bus.out_valid <= 1'b0;
            bus.overrun   <= 1'b0;
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                snap_in[i]   <= '0;
                snap_gain[i] <= '0;
            end
        end else begin
            bus.out_valid <= 1'b0;
            // A strobe outside IDLE is dropped and remembered until reset.
            if (bus.audio_clk_en && state != ST_IDLE) begin
                bus.overrun <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (bus.audio_clk_en) begin
                        for (int i = 0; i < NUM_CHANNELS; i++) begin
                            snap_in[i]   <= bus.in[i];
                            snap_gain[i] <= bus.gain[i];
                        end
                        acc   <= '0;
                        idx   <= '0;
                        state <= ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    acc <= acc + ACC_W'(prod);
                    if (idx == LAST_IDX) begin
                        state <= ST_SAT;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                ST_SAT: begin
`ifdef DK_MIXER_DC_BLOCK_EN
                    state <= ST_DC;
`else
                    bus.out       <= mix;
                    bus.out_valid <= 1'b1;
                    state         <= ST_IDLE;
`endif
                end
                ST_DC: begin
`ifdef DK_MIXER_DC_BLOCK_EN
                    if (dc_valid) begin
                        bus.out       <= dc_y;
                        bus.out_valid <= 1'b1;
                    end
`endif
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
